// File: rtl/aes_block_serializer_pkg.sv
// Shared types and constants for the AES result-block serializer
// (128-bit block out as four 32-bit stream beats).
package aes_block_serializer_pkg;

  localparam int unsigned AES_BLOCK_W  = 128;
  localparam int unsigned AES_WORD_W   = 32;
  localparam int unsigned AES_NB_WORDS = 4;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

  // Status bundle exported into the engine flags structure
  typedef struct packed {
    logic        busy;
    logic [1:0]  beat_idx;
    logic [15:0] blocks_done;
  } ser_flags_t;

endpackage

// File: rtl/aes_block_serializer_if.sv
// Beat stream carrying serialized AES words (data, byte strobe, valid/ready).
interface aes_block_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/aes_block_serializer.sv
// Takes one AES result block per handshake and emits it word 0 first as
// NB_BEATS stream beats, with zero-bubble chaining of consecutive blocks.
module aes_block_serializer
  import aes_block_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AES_WORD_W,
  parameter int unsigned NB_BEATS   = AES_NB_WORDS,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned IDX_W     = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1,
  localparam int unsigned BLK_W     = DATA_WIDTH * NB_BEATS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  input  logic [BLK_W-1:0]      blk_data_i,
  aes_block_serializer_if.master d_o,
  output logic [IDX_W-1:0]      beat_idx_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  blocks_done_o
);

  ser_state_t           state_q, state_d;
  logic [BLK_W-1:0]     blk_q, blk_d;
  logic [IDX_W-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic beat_last_s;
  logic beat_hs_s;
  logic accept_s;

  assign beat_last_s = (beat_q == IDX_W'(NB_BEATS - 1));
  assign beat_hs_s   = (state_q == SER_SEND) && d_o.ready;
  assign accept_s    = blk_valid_i && blk_ready_o;

  // Upstream ready: free when idle, or when the last beat is leaving now
  always_comb begin
    blk_ready_o = 1'b0;
    if (state_q == SER_IDLE) begin
      blk_ready_o = 1'b1;
    end else if (beat_last_s && d_o.ready) begin
      blk_ready_o = 1'b1;
    end else begin
      blk_ready_o = 1'b0;
    end
  end

  // Next-state logic; clear_i overrides accept and beat handshakes
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = SER_IDLE;
      beat_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SER_IDLE: begin
          if (accept_s) begin
            state_d = SER_SEND;
            blk_d   = blk_data_i;
            beat_d  = '0;
          end else begin
            state_d = SER_IDLE;
          end
        end
        SER_SEND: begin
          if (beat_hs_s && beat_last_s) begin
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            beat_d = '0;
            if (accept_s) begin
              state_d = SER_SEND;
              blk_d   = blk_data_i;
            end else begin
              state_d = SER_IDLE;
            end
          end else if (beat_hs_s) begin
            beat_d = beat_q + IDX_W'(1);
          end else begin
            beat_d = beat_q;
          end
        end
        default: begin
          state_d = SER_IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SER_IDLE;
      blk_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_o.valid     = (state_q == SER_SEND);
  assign d_o.data      = blk_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
  assign d_o.strb      = '1;
  assign beat_idx_o    = beat_q;
  assign busy_o        = (state_q == SER_SEND);
  assign blocks_done_o = cnt_q;

endmodule
